// File: rtl/alu_muldiv.sv
// Iterative signed multiply / floor-divide / floor-modulo unit (IDLE -> RUN -> DONE).
// Define ALU_MULDIV_FAST_MUL_EN to replace the shift-add MUL with a single-cycle multiplier.
module alu_muldiv #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             div_zero
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] OP_MUL = 2'b00;
    localparam logic [1:0] OP_DIV = 2'b01;
    localparam logic [1:0] OP_MOD = 2'b10;
    localparam logic [1:0] OP_RSV = 2'b11;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_reg, state_next;
    logic [1:0]       op_reg;
    logic [WIDTH-1:0] b_reg;
    logic             a_neg_reg;
    logic [CW-1:0]    count_reg;
    logic [WIDTH-1:0] acc_reg;    // product accumulator (MUL) or partial remainder (DIV/MOD)
    logic [WIDTH-1:0] shf_reg;    // multiplier shifting right (MUL) or dividend->quotient (DIV/MOD)
    logic [WIDTH-1:0] mcand_reg;
    logic             done_reg;
    logic [WIDTH-1:0] result_reg;
    logic             div_zero_reg;

    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x);
        return x[WIDTH-1] ? -x : x;
    endfunction

    logic             accept;
    logic             skip_run;
    logic             b_neg;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH:0]   rem_shift;
    logic [WIDTH:0]   rem_trial;
    logic [WIDTH-1:0] mul_result;
    logic [WIDTH-1:0] q_trunc, r_trunc, q_floor, r_floor;
    logic             floor_fix;
    logic             is_div_zero;
    logic [WIDTH-1:0] final_result;

    assign accept = (state_reg == IDLE) && start;
    assign b_neg  = b_reg[WIDTH-1];
    assign b_mag  = magnitude(b_reg);

    // One restoring-division step: bring down the next dividend bit, try subtracting the divisor.
    assign rem_shift = {acc_reg, shf_reg[WIDTH-1]};
    assign rem_trial = rem_shift - {1'b0, b_mag};

`ifdef ALU_MULDIV_FAST_MUL_EN
    logic [WIDTH-1:0] fast_prod;
    assign fast_prod  = src_a * src_b;
    assign skip_run   = (op == OP_RSV) || (op == OP_MUL) ||
                        (((op == OP_DIV) || (op == OP_MOD)) && (src_b == '0));
    assign mul_result = acc_reg;
`else
    assign skip_run   = (op == OP_RSV) ||
                        (((op == OP_DIV) || (op == OP_MOD)) && (src_b == '0));
    assign mul_result = (a_neg_reg ^ b_neg) ? -acc_reg : acc_reg;
`endif

    // Truncated quotient/remainder, then nudge toward minus infinity when signs differ.
    assign q_trunc     = (a_neg_reg ^ b_neg) ? -shf_reg : shf_reg;
    assign r_trunc     = a_neg_reg ? -acc_reg : acc_reg;
    assign floor_fix   = (acc_reg != '0) && (a_neg_reg != b_neg);
    assign q_floor     = floor_fix ? (q_trunc - WIDTH'(1)) : q_trunc;
    assign r_floor     = floor_fix ? (r_trunc + b_reg) : r_trunc;
    assign is_div_zero = ((op_reg == OP_DIV) || (op_reg == OP_MOD)) && (b_reg == '0);

    always_comb begin
        final_result = '0;
        case (op_reg)
            OP_MUL:  final_result = mul_result;
            OP_DIV:  final_result = is_div_zero ? '0 : q_floor;
            OP_MOD:  final_result = is_div_zero ? '0 : r_floor;
            default: final_result = '0;
        endcase
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = skip_run ? DONE : RUN;
            RUN:     if (count_reg == CW'(WIDTH - 1)) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg    <= IDLE;
            op_reg       <= '0;
            b_reg        <= '0;
            a_neg_reg    <= 1'b0;
            count_reg    <= '0;
            acc_reg      <= '0;
            shf_reg      <= '0;
            mcand_reg    <= '0;
            done_reg     <= 1'b0;
            result_reg   <= '0;
            div_zero_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            done_reg  <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        op_reg       <= op;
                        b_reg        <= src_b;
                        a_neg_reg    <= src_a[WIDTH-1];
                        count_reg    <= '0;
                        acc_reg      <= '0;
                        mcand_reg    <= magnitude(src_a);
                        shf_reg      <= (op == OP_MUL) ? magnitude(src_b) : magnitude(src_a);
                        div_zero_reg <= 1'b0;
`ifdef ALU_MULDIV_FAST_MUL_EN
                        if (op == OP_MUL) acc_reg <= fast_prod;
`endif
                    end
                end
                RUN: begin
                    count_reg <= count_reg + CW'(1);
                    if (op_reg == OP_MUL) begin
                        if (shf_reg[0]) acc_reg <= acc_reg + mcand_reg;
                        mcand_reg <= mcand_reg << 1;
                        shf_reg   <= shf_reg >> 1;
                    end else if (!rem_trial[WIDTH]) begin
                        acc_reg <= rem_trial[WIDTH-1:0];
                        shf_reg <= {shf_reg[WIDTH-2:0], 1'b1};
                    end else begin
                        acc_reg <= rem_shift[WIDTH-1:0];
                        shf_reg <= {shf_reg[WIDTH-2:0], 1'b0};
                    end
                end
                DONE: begin
                    done_reg     <= 1'b1;
                    result_reg   <= final_result;
                    div_zero_reg <= is_div_zero;
                end
                default: ;
            endcase
        end
    end

    assign busy     = (state_reg != IDLE);
    assign done     = done_reg;
    assign result   = result_reg;
    assign div_zero = div_zero_reg;
endmodule

// File: tb/tb_alu_muldiv.sv
// Scoreboard bench for alu_muldiv: driver pushes expected results, a negedge monitor pops on done.
module tb_alu_muldiv;
    localparam int W = 16;
    localparam int LAT_NORMAL = W + 1;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         start = 1'b0;
    logic [1:0]   op = 2'b00;
    logic [W-1:0] src_a = '0;
    logic [W-1:0] src_b = '0;
    logic         busy, done, div_zero;
    logic [W-1:0] result;

    alu_muldiv #(.WIDTH(W)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .op(op),
        .src_a(src_a), .src_b(src_b), .busy(busy), .done(done),
        .result(result), .div_zero(div_zero)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] res;
        logic         dz;
        int           due;
        string        tag;
    } exp_t;
    exp_t sb_q[$];

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Reference model: plain signed arithmetic with floor rounding.
    function automatic logic [W-1:0] ref_res(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        int sa, sb, q, p;
        sa = int'($signed(a));
        sb = int'($signed(b));
        p  = 0;
        case (o)
            2'd0: p = sa * sb;
            2'd1, 2'd2: begin
                if (sb != 0) begin
                    q = $rtoi($floor($itor(sa) / $itor(sb)));
                    p = (o == 2'd1) ? q : (sa - q * sb);
                end
            end
            default: p = 0;
        endcase
        return p[W-1:0];
    endfunction

    function automatic logic ref_dz(input logic [1:0] o, input logic [W-1:0] b);
        return (o == 2'd1 || o == 2'd2) && (b == '0);
    endfunction

    function automatic int ref_lat(input logic [1:0] o, input logic [W-1:0] b);
        return ((o == 2'd3) || ref_dz(o, b)) ? 1 : LAT_NORMAL;
    endfunction

    // Monitor: one line per completed transaction.
    always @(negedge clk) begin
        exp_t e;
        if (reset_n && done === 1'b1) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 result=%0h, expected no done", result);
            end else begin
                e = sb_q.pop_front();
                check({e.tag, " result"}, 32'(result), 32'(e.res));
                check({e.tag, " div_zero"}, 32'(div_zero), 32'(e.dz));
                check({e.tag, " done_cycle"}, 32'(cyc), 32'(e.due));
                $display("txn %-14s result=%04h div_zero=%0d cycle=%0d", e.tag, result, div_zero, cyc);
            end
        end
    end

    // Drive a request at a negedge; the next posedge is the accepting edge.
    task automatic issue(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                         input string tag, input bit hold);
        exp_t e;
        op = o; src_a = a; src_b = b; start = 1'b1;
        @(posedge clk);
        #1;
        e.res = ref_res(o, a, b);
        e.dz  = ref_dz(o, b);
        e.due = cyc + ref_lat(o, b);
        e.tag = tag;
        sb_q.push_back(e);
        if (!hold) begin
            start = 1'b0;
            op    = 2'($urandom);
            src_a = W'($urandom);
            src_b = W'($urandom);
        end
    endtask

    task automatic wait_done(input string tag, input int exp_busy);
        int  bc;
        bit  seen;
        bc   = 0;
        seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge clk);
            if (done === 1'b1) seen = 1'b1;
            else if (busy === 1'b1) bc++;
        end
        check({tag, " done_seen"}, 32'(seen), 32'd1);
        check({tag, " busy_cycles"}, 32'(bc), 32'(exp_busy));
    endtask

    task automatic run_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b, input string tag);
        issue(o, a, b, tag, 1'b0);
        wait_done(tag, ref_lat(o, b));
    endtask

    initial begin
        int n0, dones;
        logic [1:0]   ro;
        logic [W-1:0] ra, rb;

        #1;
        check("reset result", 32'(result), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset div_zero", 32'(div_zero), 32'd0);
        @(negedge clk); @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        run_op(2'd0, 16'd7, 16'hFFFD, "mul_7_m3");
        run_op(2'd1, 16'hFFF9, 16'd2, "div_m7_2");
        run_op(2'd2, 16'hFFF9, 16'd2, "mod_m7_2");
        run_op(2'd2, 16'd7, 16'hFFFE, "mod_7_m2");
        run_op(2'd1, 16'h8000, 16'hFFFF, "div_min_m1");
        run_op(2'd1, 16'd5, 16'd0, "div_5_0");
        run_op(2'd0, 16'd2, 16'd3, "mul_2_3");
        run_op(2'd3, 16'd9, 16'd9, "reserved");
        run_op(2'd2, 16'd12, 16'd0, "mod_12_0");

        // Start pulses during a running MUL must be ignored.
        issue(2'd0, 16'd100, 16'd100, "mul_100_100", 1'b0);
        n0 = cyc;
        dones = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (done === 1'b1) dones++;
            if (cyc - n0 == 5 || cyc - n0 == 16) begin
                start = 1'b1; op = 2'd0; src_a = W'($urandom); src_b = W'($urandom);
            end else begin
                start = 1'b0;
            end
        end
        check("ignored_start done_pulses", 32'(dones), 32'd1);

        // Reset in the middle of a DIV: outputs clear at once, no done.
        issue(2'd1, 16'd1000, 16'd7, "div_aborted", 1'b0);
        n0 = cyc;
        while (cyc - n0 < 8) @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("abort result", 32'(result), 32'd0);
        check("abort busy", 32'(busy), 32'd0);
        check("abort done", 32'(done), 32'd0);
        check("abort div_zero", 32'(div_zero), 32'd0);
        sb_q.delete();
        @(negedge clk); @(negedge clk);
        reset_n = 1'b1;
        repeat (25) @(negedge clk);
        run_op(2'd1, 16'd1000, 16'd7, "div_1000_7");

        // Start held high: back-to-back MUL 3x4 every W+2 cycles.
        issue(2'd0, 16'd3, 16'd4, "mul_3_4_hold", 1'b1);
        for (int k = 0; k < 3; k++) begin
            wait_done("mul_3_4_hold", LAT_NORMAL);
            if (k < 2) begin
                exp_t e;
                e.res = 16'h000C; e.dz = 1'b0; e.due = cyc + 1 + LAT_NORMAL; e.tag = "mul_3_4_hold";
                sb_q.push_back(e);
            end else begin
                start = 1'b0;
            end
        end

        for (int t = 0; t < 60; t++) begin
            int sel;
            sel = $urandom_range(0, 9);
            ro  = (sel < 4) ? 2'd0 : (sel < 7) ? 2'd1 : (sel < 9) ? 2'd2 : 2'd3;
            ra  = W'($urandom);
            rb  = W'($urandom);
            case ($urandom_range(0, 9))
                0: rb = '0;
                1: ra = 16'h8000;
                2: rb = 16'hFFFF;
                3: rb = W'($urandom_range(1, 9));
                default: ;
            endcase
            run_op(ro, ra, rb, "random");
        end

        repeat (3) @(negedge clk);
        check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/alu_muldiv.md
ALU_MULDIV -- requirements
Module: alu_muldiv

Interface
REQ-001 SHALL have parameter: WIDTH, 16, operand/result width in bits; iteration count equals WIDTH.
REQ-002 SHALL have port: clk  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port: reset_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port: start  input  1  request; accepted only in IDLE.
REQ-005 SHALL have port: op  input  2  00 MUL, 01 DIV, 10 MOD, 11 reserved.
REQ-006 SHALL have port: src_a  input  WIDTH  signed two's-complement operand (rY value).
REQ-007 SHALL have port: src_b  input  WIDTH  signed two's-complement operand (rZ value).
REQ-008 SHALL have port: busy  output  1  high in RUN and DONE states.
REQ-009 SHALL have port: done  output  1  single-cycle pulse, result valid.
REQ-010 SHALL have port: result  output  WIDTH  product, floor-quotient or floor-remainder.
REQ-011 SHALL have port: div_zero  output  1  set with done when DIV/MOD had src_b == 0.

Function
REQ-012 SHALL implement FSM states IDLE, RUN, DONE; IDLE -> RUN on accepted start, RUN -> DONE after WIDTH iteration cycles, DONE -> IDLE unconditionally after one cycle.
REQ-013 SHALL register op, src_a, src_b on the accepting edge; input changes afterwards SHALL not affect the operation.
REQ-014 SHALL, for MUL, compute by iterative shift-add on operand magnitudes, one bit per RUN cycle, sign applied at end; result = low WIDTH bits of the exact product.
REQ-015 SHALL, for DIV/MOD, perform restoring division on magnitudes, one quotient bit per RUN cycle, then apply floor semantics: truncated q, r; if r != 0 and sign(src_a) != sign(src_b) then q = q-1, r = r+src_b.
REQ-016 SHALL give MOD remainder the sign of src_b (or zero); DIV result truncated to WIDTH bits (-32768 DIV -1 = 0x8000).
REQ-017 SHALL, on DIV/MOD with src_b == 0, skip RUN: go IDLE -> DONE on the accepting edge, result = 0, div_zero = 1.
REQ-018 SHALL, on op 11, skip RUN: IDLE -> DONE, result = 0, div_zero = 0.
REQ-019 SHALL, for normal ops, assert done exactly WIDTH+1 rising edges after the accepting edge (17 for WIDTH=16).
REQ-020 SHALL ignore start while busy (RUN or DONE); no queueing.
REQ-021 SHALL hold result and div_zero stable from done until the next accepted start; div_zero clears on next accept.
REQ-022 SHALL accept a new start in the cycle immediately after done (back-to-back rate WIDTH+2 cycles).

Reset
REQ-023 SHALL, on reset_n low, asynchronously force state IDLE, busy 0, done 0, result 0, div_zero 0, internal accumulators 0.
REQ-024 SHALL abort any in-flight operation on reset with no done pulse; first accept after reset_n rises behaves as from power-up.

Configuration
REQ-025 SHALL honour macro ALU_MULDIV_FAST_MUL_EN: when defined, MUL uses a single-cycle combinational multiplier and goes IDLE -> DONE on the accepting edge (done 1 edge after accept); DIV/MOD unchanged.
REQ-026 SHALL, when ALU_MULDIV_FAST_MUL_EN is undefined, use the iterative MUL of REQ-014 with latency per REQ-019; results SHALL be bit-identical in both builds.

Verification
REQ-027 SHALL cover: MUL 7 x -3 -> result 0xFFEB, done exactly 17 edges after accept (1 edge with ALU_MULDIV_FAST_MUL_EN), busy high 17 cycles.
REQ-028 SHALL cover: DIV -7,2 -> 0xFFFC (-4); MOD -7,2 -> 0x0001; MOD 7,-2 -> 0xFFFF (-1); DIV -32768,-1 -> 0x8000.
REQ-029 SHALL cover: DIV 5,0 -> done 1 edge after accept, result 0, div_zero 1; following MUL 2,3 -> 6 with div_zero 0.
REQ-030 SHALL cover: start pulsed with new operands at cycles 5 and 16 of a running MUL 100 x 100 -> ignored, result 0x2710, one done pulse only.
REQ-031 SHALL cover: reset_n low at RUN cycle 8 of DIV 1000,7 -> outputs zero immediately, no done; re-issued DIV 1000,7 -> 0x008E.
REQ-032 SHALL cover: start held high continuously with MUL 3,4 -> done pulses every 18 cycles, result 0x000C each time.
